// File: rtl/usb_reader_pkg.sv
// Shared types and constants for the USB staging-buffer reader.
package usb_reader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StAddr,
    StLatch,
    StWaitTxe,
    StStrobe,
    StRecover
  } reader_state_e;

  localparam logic [7:0]  HDR_SYNC  = 8'hA5;
  localparam int unsigned HALF_SIZE = 512;

endpackage

// File: rtl/usb_buff_reader_if.sv
// Buffer read port plus FT245-style USB FIFO write pins.
interface usb_buff_reader_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8
) ();

  logic [ADDR_W-1:0] raddr_usbbuff;
  logic              rclk_usbbuff;
  logic [DATA_W-1:0] q_usbbuff;
  logic              txe_n;
  logic              wr_n;
  logic [DATA_W-1:0] usb_data;

  modport master (
    output raddr_usbbuff, rclk_usbbuff, wr_n, usb_data,
    input  q_usbbuff, txe_n
  );

  modport slave (
    input  raddr_usbbuff, rclk_usbbuff, wr_n, usb_data,
    output q_usbbuff, txe_n
  );

endinterface

// File: rtl/usb_fifo_strobe.sv
// One-byte FIFO write engine: wait for TXE_N low, hold WR_N low WR_PULSE cycles, recover.
module usb_fifo_strobe
  import usb_reader_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned WR_PULSE = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  input  logic              txe_n,
  output logic              wr_n,
  output logic [DATA_W-1:0] usb_data,
  output logic              done
);

  localparam int unsigned CntW = (WR_PULSE > 1) ? $clog2(WR_PULSE) : 1;

  reader_state_e     state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              wr_n_q, wr_n_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_n_d  = wr_n_q;
    data_d  = data_q;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          data_d  = data;
          state_d = StWaitTxe;
        end
      end
      StWaitTxe: begin
        if (!txe_n) begin
          wr_n_d  = 1'b0;
          cnt_d   = CntW'(WR_PULSE - 1);
          state_d = StStrobe;
        end
      end
      StStrobe: begin
        if (cnt_q == '0) begin
          wr_n_d  = 1'b1;
          state_d = StRecover;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StRecover: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      wr_n_q  <= 1'b1;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_n_q  <= wr_n_d;
      data_q  <= data_d;
    end
  end

  assign wr_n     = wr_n_q;
  assign usb_data = data_q;

endmodule

// File: rtl/usb_buff_reader.sv
// Drains completed 512-byte halves of the USB staging buffer into an FT245-style FIFO.
// Define USB_HEADER_EN to prefix each half with 0xA5 and {half, frame counter}.
module usb_buff_reader
  import usb_reader_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned WR_PULSE   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [1:0]          bufready,
  output logic                busy,
  output logic                overrun,
  usb_buff_reader_if.master   bus
);

  localparam int unsigned OFF_W = ADDR_W - 1;
`ifdef USB_HEADER_EN
  localparam bit HdrEn = 1'b1;
`else
  localparam bit HdrEn = 1'b0;
`endif

  reader_state_e     state_q, state_d;
  logic [1:0]        pend_q, pend_d, pend_clr, busy_mask;
  logic              half_q, half_d, last_q, last_d;
  logic [OFF_W-1:0]  offset_q, offset_d;
  logic [1:0]        lat_q, lat_d;
  logic              overrun_q, overrun_d;
  logic              start, done, sel_valid, sel_half;
  logic [DATA_W-1:0] tx_byte;
  logic              hdr_active, hdr_second;
  logic [DATA_W-1:0] hdr_byte;

  // Round-robin only matters when both halves are waiting.
  assign sel_valid = |pend_q;
  assign sel_half  = (&pend_q) ? ~last_q : pend_q[1];

  always_comb begin
    state_d  = state_q;
    half_d   = half_q;
    last_d   = last_q;
    offset_d = offset_q;
    lat_d    = lat_q;
    pend_clr = 2'b00;
    start    = 1'b0;
    tx_byte  = '0;
    case (state_q)
      StIdle: begin
        if (ena && sel_valid) begin
          pend_clr[sel_half] = 1'b1;
          half_d             = sel_half;
          last_d             = sel_half;
          lat_d              = '0;
          state_d            = HdrEn ? StHdr : StAddr;
        end
      end
      StHdr: begin
        if (ena) begin
          start   = 1'b1;
          tx_byte = hdr_byte;
          state_d = StWaitTxe;
        end
      end
      StAddr: begin
        if (ena) begin
          if (lat_q == 2'(RD_LATENCY - 1)) begin
            lat_d   = '0;
            state_d = StLatch;
          end else begin
            lat_d = lat_q + 1'b1;
          end
        end
      end
      StLatch: begin
        start   = 1'b1;
        tx_byte = bus.q_usbbuff;
        state_d = StWaitTxe;
      end
      StWaitTxe: begin
        if (done) begin
          if (hdr_active) begin
            state_d = hdr_second ? StAddr : StHdr;
          end else if (&offset_q) begin
            offset_d = '0;
            state_d  = StIdle;
          end else begin
            offset_d = offset_q + 1'b1;
            state_d  = StAddr;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Set has priority over the selection clear.
  assign busy_mask = (state_q != StIdle) ? (half_q ? 2'b10 : 2'b01) : 2'b00;
  assign pend_d    = (pend_q & ~pend_clr) | bufready;
  assign overrun_d = overrun_q | (|(bufready & (pend_q | busy_mask)));

`ifdef USB_HEADER_EN
  logic [6:0] frame_q, frame_d;
  logic       hdr_idx_q, hdr_idx_d, in_hdr_q, in_hdr_d;

  always_comb begin
    frame_d   = frame_q;
    hdr_idx_d = hdr_idx_q;
    in_hdr_d  = in_hdr_q;
    if (state_q == StIdle) hdr_idx_d = 1'b0;
    if (state_q == StHdr && ena) in_hdr_d = 1'b1;
    if (state_q == StWaitTxe && done && in_hdr_q) begin
      in_hdr_d = 1'b0;
      if (hdr_idx_q) frame_d = frame_q + 7'd1;
      else           hdr_idx_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q   <= '0;
      hdr_idx_q <= 1'b0;
      in_hdr_q  <= 1'b0;
    end else begin
      frame_q   <= frame_d;
      hdr_idx_q <= hdr_idx_d;
      in_hdr_q  <= in_hdr_d;
    end
  end

  assign hdr_active = in_hdr_q;
  assign hdr_second = hdr_idx_q;
  assign hdr_byte   = hdr_idx_q ? DATA_W'({half_q, frame_q}) : DATA_W'(HDR_SYNC);
`else
  assign hdr_active = 1'b0;
  assign hdr_second = 1'b0;
  assign hdr_byte   = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pend_q    <= 2'b00;
      half_q    <= 1'b0;
      last_q    <= 1'b1;
      offset_q  <= '0;
      lat_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      half_q    <= half_d;
      last_q    <= last_d;
      offset_q  <= offset_d;
      lat_q     <= lat_d;
      overrun_q <= overrun_d;
    end
  end

  usb_fifo_strobe #(
    .DATA_W  (DATA_W),
    .WR_PULSE(WR_PULSE)
  ) u_strobe (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .data    (tx_byte),
    .txe_n   (bus.txe_n),
    .wr_n    (bus.wr_n),
    .usb_data(bus.usb_data),
    .done    (done)
  );

  assign bus.raddr_usbbuff = {half_q, offset_q};
  assign bus.rclk_usbbuff  = clk;
  assign busy              = (state_q != StIdle);
  assign overrun           = overrun_q;

endmodule

// File: tb/tb_usb_buff_reader.sv
// Self-checking bench for usb_buff_reader: byte-stream scoreboard built from buffer contents.
module tb_usb_buff_reader;
  import usb_reader_pkg::*;

  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned RD_LATENCY = 1;
  localparam int unsigned WR_PULSE   = 2;
  localparam int unsigned BYTE_CYC   = RD_LATENCY + WR_PULSE + 3;
`ifdef USB_HEADER_EN
  localparam int unsigned HDR_N = 2;
`else
  localparam int unsigned HDR_N = 0;
`endif
  localparam int unsigned HDR_CYC  = HDR_N * (WR_PULSE + 3);
  localparam int unsigned HALF_CYC = HALF_SIZE * BYTE_CYC + HDR_CYC;

  logic       clk = 1'b0;
  logic       rst_n, ena, busy, overrun;
  logic [1:0] bufready;

  usb_buff_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  usb_buff_reader #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .RD_LATENCY(RD_LATENCY),
    .WR_PULSE  (WR_PULSE)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .bufready(bufready),
    .busy    (busy),
    .overrun (overrun),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Synchronous-read staging buffer model.
  logic [7:0] mem [1024];
  always @(posedge bus.rclk_usbbuff) bus.q_usbbuff <= mem[bus.raddr_usbbuff];

  int txe_mode = 0;  // 0: ready, 1: full, 2: random
  always @(negedge clk) begin
    case (txe_mode)
      0:       bus.txe_n = 1'b0;
      1:       bus.txe_n = 1'b1;
      default: bus.txe_n = ($urandom_range(0, 2) != 0);
    endcase
  end

  logic [7:0] exp_q[$];
  logic [7:0] cap_q[$];
  int frame_m = 0;
  int low_run = 0;
  int pulse_err = 0;
  int errors = 0;
  int checks = 0;

  // Capture each byte as WR_N returns high and measure the low-pulse width.
  always @(negedge clk) begin
    if (!rst_n) low_run = 0;
    else if (bus.wr_n === 1'b0) low_run++;
    else if (low_run != 0) begin
      if (low_run != WR_PULSE) pulse_err++;
      cap_q.push_back(bus.usb_data);
      low_run = 0;
    end
  end

  task automatic add_half(input int h);
`ifdef USB_HEADER_EN
    logic [7:0] hb;
    hb = {h[0], frame_m[6:0]};
    exp_q.push_back(8'hA5);
    exp_q.push_back(hb);
    frame_m++;
`endif
    for (int i = 0; i < int'(HALF_SIZE); i++) exp_q.push_back(mem[h * int'(HALF_SIZE) + i]);
  endtask

  function automatic int first_diff();
    if (cap_q.size() != exp_q.size()) return -2;
    foreach (exp_q[i]) if (cap_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic fill(input bit rnd);
    for (int i = 0; i < 1024; i++) mem[i] = rnd ? 8'($urandom) : i[7:0];
  endtask

  task automatic clear_model();
    exp_q.delete();
    cap_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bufready = 2'b00;
    clear_model();
    frame_m = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic pulse(input logic [1:0] v);
    @(posedge clk); #1;
    bufready = v;
    @(posedge clk); #1;
    bufready = 2'b00;
  endtask

  task automatic wait_drain(input int budget, output int cyc, output bit ok);
    cyc = 0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (busy) cyc++;
      if (!busy && cap_q.size() >= exp_q.size()) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_cap(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (cap_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.raddr_usbbuff !== '0) begin errors++; $display("FAIL reset_raddr: got %0h want 0", bus.raddr_usbbuff); end
    checks++; if (bus.wr_n !== 1'b1) begin errors++; $display("FAIL reset_wr_n: got %b want 1", bus.wr_n); end
    checks++; if (bus.usb_data !== '0) begin errors++; $display("FAIL reset_usb_data: got %0h want 0", bus.usb_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_single_half();
    int cyc, d;
    bit ok;
    fill(1'b0);
    txe_mode = 0;
    clear_model();
    add_half(0);
    pulse(2'b01);
    wait_drain(10000, cyc, ok);
    d = first_diff();
    checks++; if (!ok) begin errors++; $display("FAIL single_done: got timeout want drained"); end
    checks++; if (d != -1) begin errors++; $display("FAIL single_stream: bad index %0d (got %0d bytes want %0d)", d, cap_q.size(), exp_q.size()); end
    checks++; if (cyc != int'(HALF_CYC)) begin errors++; $display("FAIL single_busy_cycles: got %0d want %0d", cyc, HALF_CYC); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL single_overrun: got %b want 0", overrun); end
    checks++; if (pulse_err != 0) begin errors++; $display("FAIL single_wr_pulse: got %0d bad pulses want 0", pulse_err); end
  endtask

  // Half 0 was served last, so with both pending half 1 must go first.
  task automatic test_rotate();
    int cyc, d;
    bit ok;
    fill(1'b1);
    txe_mode = 2;
    clear_model();
    add_half(1);
    add_half(0);
    pulse(2'b11);
    wait_drain(40000, cyc, ok);
    txe_mode = 0;
    d = first_diff();
    checks++; if (!ok) begin errors++; $display("FAIL rotate_done: got timeout want drained"); end
    checks++; if (d != -1) begin errors++; $display("FAIL rotate_stream: bad index %0d (got %0d bytes want %0d)", d, cap_q.size(), exp_q.size()); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rotate_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_back_to_back();
    int cyc, d;
    bit ok;
    do_reset();
    fill(1'b1);
    txe_mode = 0;
    add_half(0);
    add_half(1);
    pulse(2'b11);
    wait_drain(20000, cyc, ok);
    d = first_diff();
    checks++; if (!ok) begin errors++; $display("FAIL b2b_done: got timeout want drained"); end
    checks++; if (d != -1) begin errors++; $display("FAIL b2b_stream: bad index %0d (got %0d bytes want %0d)", d, cap_q.size(), exp_q.size()); end
    checks++; if (cyc != 2 * int'(HALF_CYC)) begin errors++; $display("FAIL b2b_busy_cycles: got %0d want %0d", cyc, 2 * HALF_CYC); end
  endtask

  task automatic test_txe_stall();
    int cyc, d, bad_wr, bad_data;
    bit ok;
    fill(1'b1);
    txe_mode = 0;
    clear_model();
    add_half(0);
    pulse(2'b01);
    wait_cap(100 + HDR_N, 5000, ok);
    txe_mode = 1;
    checks++; if (!ok) begin errors++; $display("FAIL stall_reach: got timeout want byte 100"); end
    repeat (5) @(posedge clk);
    #1;
    bad_wr = 0;
    bad_data = 0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk); #1;
      if (bus.wr_n !== 1'b1) bad_wr++;
      if (bus.usb_data !== exp_q[100 + HDR_N]) bad_data++;
    end
    checks++; if (bad_wr != 0) begin errors++; $display("FAIL stall_wr_n: got %0d low cycles want 0", bad_wr); end
    checks++; if (bad_data != 0) begin errors++; $display("FAIL stall_data: got %0h want %0h", bus.usb_data, exp_q[100 + HDR_N]); end
    txe_mode = 0;
    wait_drain(10000, cyc, ok);
    d = first_diff();
    checks++; if (d != -1 || !ok) begin errors++; $display("FAIL stall_stream: bad index %0d (got %0d bytes want %0d)", d, cap_q.size(), exp_q.size()); end
  endtask

  task automatic test_ena_pause();
    int cyc, d, n, bad_wr, bad_busy;
    bit ok;
    fill(1'b1);
    clear_model();
    add_half(1);
    pulse(2'b10);
    wait_cap(50 + HDR_N, 5000, ok);
    ena = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    n = cap_q.size();
    bad_wr = 0;
    bad_busy = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (bus.wr_n !== 1'b1) bad_wr++;
      if (busy !== 1'b1) bad_busy++;
    end
    checks++; if (bad_wr != 0) begin errors++; $display("FAIL pause_wr_n: got %0d low cycles want 0", bad_wr); end
    checks++; if (bad_busy != 0) begin errors++; $display("FAIL pause_busy: got %0d idle cycles want 0", bad_busy); end
    checks++; if (cap_q.size() != n || n != 50 + HDR_N) begin errors++; $display("FAIL pause_count: got %0d want %0d", cap_q.size(), 50 + HDR_N); end
    ena = 1'b1;
    wait_drain(10000, cyc, ok);
    d = first_diff();
    checks++; if (d != -1 || !ok) begin errors++; $display("FAIL pause_stream: bad index %0d (got %0d bytes want %0d)", d, cap_q.size(), exp_q.size()); end
  endtask

  task automatic test_overrun();
    int cyc, d;
    bit ok;
    fill(1'b1);
    clear_model();
    add_half(0);
    pulse(2'b01);
    repeat (20) @(posedge clk);
    pulse(2'b01);
    add_half(0);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b want 1", overrun); end
    wait_drain(20000, cyc, ok);
    d = first_diff();
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
    checks++; if (d != -1 || !ok) begin errors++; $display("FAIL overrun_stream: bad index %0d (got %0d bytes want %0d)", d, cap_q.size(), exp_q.size()); end
    do_reset();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b want 0", overrun); end
  endtask

  task automatic test_reset_mid_strobe();
    int cyc, d;
    bit ok;
    fill(1'b1);
    clear_model();
    pulse(2'b01);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (bus.wr_n === 1'b0 && cap_q.size() >= 10) begin
        ok = 1'b1;
        break;
      end
    end
    checks++; if (!ok) begin errors++; $display("FAIL midrst_reach: got timeout want strobe"); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.wr_n !== 1'b1) begin errors++; $display("FAIL midrst_wr_n: got %b want 1", bus.wr_n); end
    checks++; if (busy !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL midrst_flags: got busy=%b overrun=%b want 0/0", busy, overrun); end
    checks++; if (bus.raddr_usbbuff !== '0 || bus.usb_data !== '0) begin errors++; $display("FAIL midrst_regs: got raddr=%0h data=%0h want 0/0", bus.raddr_usbbuff, bus.usb_data); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_model();
    frame_m = 0;
    add_half(0);
    pulse(2'b01);
    wait_drain(10000, cyc, ok);
    d = first_diff();
    checks++; if (d != -1 || !ok) begin errors++; $display("FAIL midrst_restart: bad index %0d (got %0d bytes want %0d)", d, cap_q.size(), exp_q.size()); end
    checks++; if (pulse_err != 0) begin errors++; $display("FAIL final_wr_pulse: got %0d bad pulses want 0", pulse_err); end
  endtask

  initial begin
    rst_n = 1'b0;
    ena = 1'b1;
    bufready = 2'b00;
    test_reset();
    test_single_half();
    test_rotate();
    test_back_to_back();
    test_txe_stall();
    test_ena_pause();
    test_overrun();
    test_reset_mid_strobe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
